ftdi_rx_reader: RTL and testbench

- Receive-side counterpart of the FT600 245-sync-FIFO write path. Reads words from the FTDI chip using RXF_N/OE_N/RD_N and buffers them in a small show-ahead FIFO.
- Presents the words to fabric logic over a valid/ready stream.
- Runs entirely in the CLK_FTDI (100 MHz) domain and replaces the tied-high RD_N/OE_N drive in the top level.

---
 rtl/ftdi_rx_reader.sv | 85 ++++++++
 tb/tb_ftdi_rx_reader.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ftdi_rx_reader.sv
// ftdi_rx_reader: FT600 245-sync-FIFO read engine feeding a show-ahead buffer with a valid/ready output
module ftdi_rx_reader #(
   parameter int DATA_W    = 32,
   parameter int BE_W      = 4,
   parameter int BUF_DEPTH = 8,
   parameter int CNT_W     = 16
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rxf_n_in,
   input  logic [DATA_W-1:0] data_in,
   input  logic [BE_W-1:0]   be_in,
   output logic              oe_n_out,
   output logic              rd_n_out,
   output logic [DATA_W-1:0] data_out,
   output logic [BE_W-1:0]   be_out,
   output logic              valid_out,
   input  logic              ready_in,
   output logic [CNT_W-1:0]  word_cnt_out
);
   localparam int AW = $clog2(BUF_DEPTH);
   localparam int EW = DATA_W + BE_W;

   typedef enum logic [1:0] {IDLE, OE, READ, PAUSE} state_t;

   state_t          state_q, state_d;
   logic            oe_n_q, oe_n_d, rd_n_q, rd_n_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]     cnt_q, cnt_d, rem;
   logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
   logic [EW-1:0]   head_q, head_d;
   logic [EW-1:0]   mem_q [BUF_DEPTH];
   logic            push, pop, space;

   always_comb begin
      push       = !rd_n_q && !rxf_n_in;
      pop        = (cnt_q != '0) && ready_in;
      rem        = cnt_q - (AW+1)'(pop);
      cnt_d      = rem + (AW+1)'(push);
      space      = cnt_d <= (AW+1)'(BUF_DEPTH - 1);
      wr_ptr_d   = wr_ptr_q + AW'(push);
      rd_ptr_d   = rd_ptr_q + AW'(pop);
      word_cnt_d = word_cnt_q + CNT_W'(push);
      // head register: keep last word when empty, bypass the incoming word when it becomes the only entry
      head_d     = (cnt_d == '0) ? head_q : (rem == '0) ? {be_in, data_in} : mem_q[rd_ptr_d];
      state_d    = rxf_n_in ? IDLE :
                   !space   ? ((state_q == IDLE) ? IDLE : PAUSE) :
                              ((state_q == IDLE) ? OE : READ);
      oe_n_d     = state_d == IDLE;
      rd_n_d     = state_d != READ;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q    <= IDLE;
         oe_n_q     <= 1'b1;
         rd_n_q     <= 1'b1;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         word_cnt_q <= '0;
         head_q     <= '0;
      end else begin
         state_q    <= state_d;
         oe_n_q     <= oe_n_d;
         rd_n_q     <= rd_n_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         word_cnt_q <= word_cnt_d;
         head_q     <= head_d;
      end
   end

   always_ff @(posedge clk_in) begin
      if (push) mem_q[wr_ptr_q] <= {be_in, data_in};
   end

   assign oe_n_out     = oe_n_q;
   assign rd_n_out     = rd_n_q;
   assign data_out     = head_q[DATA_W-1:0];
   assign be_out       = head_q[DATA_W +: BE_W];
   assign valid_out    = cnt_q != '0;
   assign word_cnt_out = word_cnt_q;
endmodule

// File: tb/tb_ftdi_rx_reader.sv
// tb_ftdi_rx_reader: FT600 source model plus scoreboard checking of the ftdi_rx_reader output stream
module tb_ftdi_rx_reader;
   localparam int DEPTH = 8;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        rxf_n_in = 1'b1;
   logic        ready_in = 1'b0;
   logic [31:0] data_in = '0;
   logic [3:0]  be_in = '0;
   logic        oe_n_out, rd_n_out, valid_out;
   logic [31:0] data_out;
   logic [3:0]  be_out;
   logic [15:0] word_cnt_out;

   ftdi_rx_reader #(.DATA_W(32), .BE_W(4), .BUF_DEPTH(DEPTH), .CNT_W(16)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rxf_n_in(rxf_n_in), .data_in(data_in), .be_in(be_in),
      .oe_n_out(oe_n_out), .rd_n_out(rd_n_out), .data_out(data_out), .be_out(be_out),
      .valid_out(valid_out), .ready_in(ready_in), .word_cnt_out(word_cnt_out)
   );

   always #5 clk_in = ~clk_in;

   logic [35:0] src_q[$];
   logic [35:0] exp_q[$];
   bit          cap;
   int          total = 0, bad = 0, pops = 0;
   logic        pv = 1'b0, pr = 1'b0, prst = 1'b1;
   logic [31:0] pd = '0;

   task automatic chk(string nm, bit ok, longint act, longint req);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, req);
      end
   endtask

   task automatic cyc(int n);
      repeat (n) @(posedge clk_in);
      #1;
   endtask

   task automatic load(int n, int base, logic [3:0] be);
      for (int i = 0; i < n; i++) begin
         src_q.push_back({be ^ 4'(i), 32'(base + i)});
         exp_q.push_back({be ^ 4'(i), 32'(base + i)});
      end
   endtask

   task automatic wait_oe();
      int n = 0;
      while (oe_n_out && n < 50) begin cyc(1); n++; end
      chk("oe_wait", !oe_n_out, oe_n_out, 0);
   endtask

   task automatic wait_wcnt(int v);
      int n = 0;
      while (word_cnt_out != 16'(v) && n < 100) begin cyc(1); n++; end
      chk("wcnt_wait", word_cnt_out == 16'(v), word_cnt_out, v);
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && (exp_q.size() != 0 || src_q.size() != 0); i++) cyc(1);
      chk("drain", exp_q.size() == 0, exp_q.size(), 0);
      cyc(2);
   endtask

   // FTDI source: a word is consumed at an edge where RD_N and RXF_N are both low
   always @(negedge clk_in) cap = !rd_n_out && !rxf_n_in && !rst_in;
   always @(posedge clk_in) begin
      #2;
      if (cap && src_q.size() != 0) void'(src_q.pop_front());
      rxf_n_in = src_q.size() == 0;
      {be_in, data_in} = (src_q.size() != 0) ? src_q[0] : 36'h0;
   end

   always @(negedge clk_in) begin
      logic [35:0] e;
      if (!rst_in) begin
         chk("cnt_bound", dut.cnt_q <= DEPTH, dut.cnt_q, DEPTH);
         if (pv && !pr && !prst) begin
            chk("hold_valid", valid_out, valid_out, 1);
            chk("hold_data", data_out == pd, data_out, pd);
         end
         if (valid_out && ready_in) begin
            if (exp_q.size() == 0) chk("unexpected_word", 1'b0, {be_out, data_out}, 0);
            else begin
               e = exp_q.pop_front();
               chk("stream_word", {be_out, data_out} == e, {be_out, data_out}, e);
               pops++;
            end
         end
      end
      pv = valid_out; pr = ready_in; pd = data_out; prst = rst_in;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lo, p0;
      cyc(2);
      chk("rst_oe_n", oe_n_out, oe_n_out, 1);
      chk("rst_rd_n", rd_n_out, rd_n_out, 1);
      chk("rst_valid", !valid_out, valid_out, 0);
      chk("rst_data", data_out == 0 && be_out == 0, {be_out, data_out}, 0);
      chk("rst_wcnt", word_cnt_out == 0, word_cnt_out, 0);
      rst_in = 1'b0;
      ready_in = 1'b1;
      // single word
      src_q.push_back({4'hF, 32'h12345678});
      exp_q.push_back({4'hF, 32'h12345678});
      wait_oe();
      chk("single_oe_lead", rd_n_out, rd_n_out, 1);
      cyc(1);
      chk("single_rd_low", !rd_n_out && !oe_n_out, {oe_n_out, rd_n_out}, 0);
      drain();
      chk("single_wcnt", word_cnt_out == 1, word_cnt_out, 1);
      chk("single_idle", oe_n_out && rd_n_out, {oe_n_out, rd_n_out}, 3);
      // 20-word burst
      p0 = pops;
      load(20, 0, 4'hA);
      wait_oe();
      lo = 0;
      for (int i = 0; i < 60; i++) begin
         cyc(1);
         if (!rd_n_out) lo++;
         else if (lo != 0) break;
      end
      chk("burst_rd_low", lo == 21, lo, 21);
      drain();
      chk("burst_pops", pops - p0 == 20, pops - p0, 20);
      chk("burst_wcnt", word_cnt_out == 21, word_cnt_out, 21);
      // backpressure fills the buffer, then full-buffer streaming
      ready_in = 1'b0;
      load(20, 100, 4'h5);
      cyc(30);
      chk("bp_wcnt", word_cnt_out == 29, word_cnt_out, 29);
      chk("bp_pause", !oe_n_out && rd_n_out, {oe_n_out, rd_n_out}, 1);
      chk("bp_head", valid_out && data_out == 100, data_out, 100);
      ready_in = 1'b1;
      cyc(1);
      for (int i = 0; i < 10; i++) begin
         chk("full_rd_low", !rd_n_out, rd_n_out, 0);
         chk("steady_cnt", dut.cnt_q == 7, dut.cnt_q, 7);
         cyc(1);
      end
      drain();
      chk("bp_wcnt_end", word_cnt_out == 41, word_cnt_out, 41);
      // RXF_N rises after 5 words, then re-asserts
      load(5, 200, 4'h3);
      wait_wcnt(46);
      cyc(1);
      chk("stop_idle", oe_n_out && rd_n_out, {oe_n_out, rd_n_out}, 3);
      cyc(3);
      chk("stop_wcnt", word_cnt_out == 46, word_cnt_out, 46);
      load(3, 300, 4'h6);
      wait_oe();
      chk("restart_oe_phase", rd_n_out, rd_n_out, 1);
      cyc(1);
      chk("restart_rd_low", !rd_n_out, rd_n_out, 0);
      drain();
      chk("restart_wcnt", word_cnt_out == 49, word_cnt_out, 49);
      // reset during READ with 3 words buffered
      ready_in = 1'b0;
      load(10, 400, 4'h9);
      wait_wcnt(52);
      chk("mid_read", !rd_n_out && valid_out, {rd_n_out, valid_out}, 1);
      rst_in = 1'b1;
      src_q.delete();
      exp_q.delete();
      cyc(1);
      chk("mrst_strobes", oe_n_out && rd_n_out, {oe_n_out, rd_n_out}, 3);
      chk("mrst_valid", !valid_out, valid_out, 0);
      chk("mrst_wcnt", word_cnt_out == 0, word_cnt_out, 0);
      chk("mrst_data", data_out == 0 && be_out == 0, {be_out, data_out}, 0);
      rst_in = 1'b0;
      ready_in = 1'b1;
      load(4, 0, 4'hC);
      drain();
      chk("post_rst_wcnt", word_cnt_out == 4, word_cnt_out, 4);
      chk("post_rst_idle", oe_n_out && rd_n_out, {oe_n_out, rd_n_out}, 3);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
